// File: rtl/pio_bus_master.sv
// Avalon-MM initiator for PIO register slaves: one read/write command at a time,
// optional write-verify readback compared under VERIFY_MASK, one response strobe per command.
module pio_bus_master #(
   parameter int                ADDR_W       = 2,
   parameter int                DATA_W       = 32,
   parameter int                READ_LATENCY = 0,
   parameter logic [DATA_W-1:0] VERIFY_MASK  = 32'h0000000F
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic              cmd_verify,
   input  logic [ADDR_W-1:0] cmd_address,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] address,
   output logic              chipselect,
   output logic              write_n,
   output logic [DATA_W-1:0] writedata,
   input  logic [DATA_W-1:0] readdata
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WR    = 3'd1,
      S_RD    = 3'd2,
      S_RWAIT = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              verify_q, verify_d;
   logic [ADDR_W-1:0] address_q, address_d;
   logic [DATA_W-1:0] writedata_q, writedata_d;
   logic              chipselect_q, chipselect_d;
   logic              write_n_q, write_n_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              sample_s;

   function automatic logic verify_mismatch(input logic [DATA_W-1:0] readback,
                                            input logic [DATA_W-1:0] written,
                                            input logic [DATA_W-1:0] mask);
      return |((readback ^ written) & mask);
   endfunction

   // Next-state logic; bus strobes are derived from the next state so they come out registered.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      verify_d    = verify_q;
      address_d   = address_q;
      writedata_d = writedata_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      sample_s    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               address_d = cmd_address;
               verify_d  = cmd_write && cmd_verify;
               rsp_err_d = 1'b0;
               if (cmd_write) begin
                  writedata_d = cmd_wdata;
                  state_d     = S_WR;
               end else begin
                  state_d     = S_RD;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WR: begin
            state_d = verify_q ? S_RD : S_RESP;
         end
         S_RD: begin
            if (READ_LATENCY == 32'sd0) begin
               sample_s = 1'b1;
               state_d  = S_RESP;
            end else begin
               cnt_d   = 2'd1;
               state_d = S_RWAIT;
            end
         end
         S_RWAIT: begin
            if (cnt_q == 2'(READ_LATENCY)) begin
               sample_s = 1'b1;
               state_d  = S_RESP;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Readback is compared against the still-held write data.
      if (sample_s) begin
         rsp_rdata_d = readdata;
         rsp_err_d   = verify_q ? verify_mismatch(readdata, writedata_q, VERIFY_MASK) : 1'b0;
      end else begin
         rsp_rdata_d = rsp_rdata_q;
      end

      chipselect_d = (state_d == S_WR) || (state_d == S_RD);
      write_n_d    = (state_d != S_WR);
      cmd_ready_d  = (state_d == S_IDLE);
      rsp_valid_d  = (state_d == S_RESP);
   end

   // State and output registers; reset aborts any command in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= 2'd0;
         verify_q     <= 1'b0;
         address_q    <= '0;
         writedata_q  <= '0;
         chipselect_q <= 1'b0;
         write_n_q    <= 1'b1;
         cmd_ready_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         verify_q     <= verify_d;
         address_q    <= address_d;
         writedata_q  <= writedata_d;
         chipselect_q <= chipselect_d;
         write_n_q    <= write_n_d;
         cmd_ready_q  <= cmd_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign rsp_err    = rsp_err_q;
   assign address    = address_q;
   assign chipselect = chipselect_q;
   assign write_n    = write_n_q;
   assign writedata  = writedata_q;

endmodule

// File: tb/tb_pio_bus_master.sv
// Bench for pio_bus_master: two instances (latency 0 / mask 0xF and latency 2 / mask 0x3),
// each with a PIO slave model, checked against a per-command transaction model.
module tb_pio_bus_master;

   localparam logic [31:0] GARB = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        reset [2];
   logic        cmd_valid [2];
   logic        cmd_ready [2];
   logic        cmd_write [2];
   logic        cmd_verify [2];
   logic [1:0]  cmd_address [2];
   logic [31:0] cmd_wdata [2];
   logic        rsp_valid [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err [2];
   logic [1:0]  address [2];
   logic        chipselect [2];
   logic        write_n [2];
   logic [31:0] writedata [2];
   logic [31:0] readdata [2];

   logic [31:0] mem [2][4] = '{default: 32'h0};
   logic [31:0] stuck [2] = '{32'h0, 32'h0};
   logic [31:0] pipe0 = GARB;
   logic [31:0] pipe1 = GARB;
   int          rsp_cnt [2] = '{0, 0};
   int          wr_cnt [2] = '{0, 0};

   logic [31:0] exp_mem [2][4];
   logic [31:0] exp_rdata [2];
   int          n_tests = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   pio_bus_master #(.ADDR_W(2), .DATA_W(32), .READ_LATENCY(0), .VERIFY_MASK(32'h0000000F)) dut0 (
      .clk(clk), .reset(reset[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
      .cmd_write(cmd_write[0]), .cmd_verify(cmd_verify[0]), .cmd_address(cmd_address[0]),
      .cmd_wdata(cmd_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
      .rsp_err(rsp_err[0]), .address(address[0]), .chipselect(chipselect[0]),
      .write_n(write_n[0]), .writedata(writedata[0]), .readdata(readdata[0]));

   pio_bus_master #(.ADDR_W(2), .DATA_W(32), .READ_LATENCY(2), .VERIFY_MASK(32'h00000003)) dut1 (
      .clk(clk), .reset(reset[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
      .cmd_write(cmd_write[1]), .cmd_verify(cmd_verify[1]), .cmd_address(cmd_address[1]),
      .cmd_wdata(cmd_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
      .rsp_err(rsp_err[1]), .address(address[1]), .chipselect(chipselect[1]),
      .write_n(write_n[1]), .writedata(writedata[1]), .readdata(readdata[1]));

   // PIO slave models: stuck bits are OR'd into stored data; instance 1 returns data two cycles late.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (chipselect[i] && !write_n[i]) mem[i][address[i]] <= writedata[i] | stuck[i];
      end
      pipe0 <= (chipselect[1] && write_n[1]) ? mem[1][address[1]] : GARB;
      pipe1 <= pipe0;
   end

   always_comb begin
      readdata[0] = (chipselect[0] && write_n[0]) ? mem[0][address[0]] : GARB;
      readdata[1] = pipe1;
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rsp_valid[i]) rsp_cnt[i] <= rsp_cnt[i] + 1;
         if (chipselect[i] && !write_n[i]) wr_cnt[i] <= wr_cnt[i] + 1;
      end
   end

   function automatic int lat_of(input int i);
      return (i == 0) ? 0 : 2;
   endfunction

   function automatic logic [31:0] mask_of(input int i);
      return (i == 0) ? 32'h0000000F : 32'h00000003;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One command through instance i; the expected cycle pattern comes from the latency rules.
   task automatic do_cmd(input int i, input logic wr, input logic vf, input logic [1:0] a,
                         input logic [31:0] d);
      logic        rd_ph;
      int          lat, wr_k, rd_k;
      logic        exp_err, exp_cs, exp_wn;
      rd_ph = !wr || vf;
      lat   = 1 + (wr ? 1 : 0) + (rd_ph ? 1 + lat_of(i) : 0);
      wr_k  = wr ? 1 : 0;
      rd_k  = !rd_ph ? 0 : (wr ? 2 : 1);
      if (wr) exp_mem[i][a] = d | stuck[i];
      exp_err = 1'b0;
      if (rd_ph) begin
         exp_rdata[i] = exp_mem[i][a];
         exp_err      = wr && (((exp_mem[i][a] ^ d) & mask_of(i)) != 32'h0);
      end
      @(negedge clk);
      chk("idle_ready", {31'h0, cmd_ready[i]}, 32'h1);
      cmd_valid[i]   = 1'b1;
      cmd_write[i]   = wr;
      cmd_verify[i]  = vf;
      cmd_address[i] = a;
      cmd_wdata[i]   = d;
      @(negedge clk);
      cmd_valid[i]   = 1'b0;
      cmd_write[i]   = ~wr;
      cmd_verify[i]  = ~vf;
      cmd_address[i] = ~a;
      cmd_wdata[i]   = ~d;
      for (int k = 1; k <= lat + 1; k++) begin
         exp_cs = (k == wr_k) || (k == rd_k);
         exp_wn = (k != wr_k);
         chk("cs_wn_rv_rdy", {28'h0, chipselect[i], write_n[i], rsp_valid[i], cmd_ready[i]},
             {28'h0, exp_cs, exp_wn, (k == lat), (k == lat + 1)});
         if (k <= lat) chk("address", {30'h0, address[i]}, {30'h0, a});
         if (k == wr_k) chk("writedata", writedata[i], d);
         if (k >= lat) chk("rsp_rdata", rsp_rdata[i], exp_rdata[i]);
         if (k == lat) chk("rsp_err", {31'h0, rsp_err[i]}, {31'h0, exp_err});
         if (k <= lat) @(negedge clk);
      end
   endtask

   initial begin
      int          acc, r0, w0, ri;
      logic        rw, rv;
      logic [1:0]  ra;
      logic [31:0] rd;
      logic [31:0] bd [3];

      for (int i = 0; i < 2; i++) begin
         reset[i] = 1'b1; cmd_valid[i] = 1'b0; cmd_write[i] = 1'b0; cmd_verify[i] = 1'b0;
         cmd_address[i] = 2'd0; cmd_wdata[i] = 32'h0; exp_rdata[i] = 32'h0;
         for (int j = 0; j < 4; j++) exp_mem[i][j] = 32'h0;
      end

      // Reset held three cycles, outputs at their reset values
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rst_cs", {31'h0, chipselect[i]}, 32'h0);
         chk("rst_write_n", {31'h0, write_n[i]}, 32'h1);
         chk("rst_ready", {31'h0, cmd_ready[i]}, 32'h0);
         chk("rst_rsp_valid", {31'h0, rsp_valid[i]}, 32'h0);
         chk("rst_rdata", rsp_rdata[i], 32'h0);
         chk("rst_address", {30'h0, address[i]}, 32'h0);
         chk("rst_writedata", writedata[i], 32'h0);
         reset[i] = 1'b0;
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) chk("post_rst_ready", {31'h0, cmd_ready[i]}, 32'h1);

      // Plain write, then plain reads at latency 0 and 2
      do_cmd(0, 1'b1, 1'b0, 2'd0, 32'h5);
      chk("slave_reg0", mem[0][0], 32'h5);
      do_cmd(0, 1'b1, 1'b0, 2'd0, 32'hA);
      do_cmd(0, 1'b0, 1'b0, 2'd0, 32'h0);
      do_cmd(1, 1'b1, 1'b0, 2'd0, 32'hA);
      do_cmd(1, 1'b0, 1'b1, 2'd0, 32'h0);

      // Write-verify against a slave with bit 2 stuck at one
      stuck[0] = 32'h4;
      stuck[1] = 32'h4;
      do_cmd(0, 1'b1, 1'b1, 2'd2, 32'h3);
      do_cmd(1, 1'b1, 1'b1, 2'd2, 32'h3);
      stuck[0] = 32'h0;
      stuck[1] = 32'h0;
      do_cmd(0, 1'b1, 1'b0, 2'd3, 32'h9);

      // cmd_valid held high across three writes
      r0 = rsp_cnt[0];
      w0 = wr_cnt[0];
      acc = 0;
      for (int j = 0; j < 3; j++) bd[j] = $urandom;
      @(negedge clk);
      cmd_valid[0] = 1'b1; cmd_write[0] = 1'b1; cmd_verify[0] = 1'b0;
      cmd_address[0] = 2'd1; cmd_wdata[0] = bd[0];
      for (int c = 0; c < 30 && acc < 3; c++) begin
         if (cmd_ready[0]) begin
            exp_mem[0][acc + 1] = bd[acc];
            acc++;
            @(negedge clk);
            if (acc == 3) begin
               cmd_valid[0] = 1'b0;
            end else begin
               cmd_address[0] = 2'(acc + 1);
               cmd_wdata[0]   = bd[acc];
            end
         end else begin
            @(negedge clk);
         end
      end
      cmd_valid[0] = 1'b0;
      repeat (6) @(negedge clk);
      chk("b2b_accepts", acc, 3);
      chk("b2b_responses", rsp_cnt[0] - r0, 3);
      chk("b2b_writes", wr_cnt[0] - w0, 3);
      for (int j = 1; j < 4; j++) chk("b2b_slave_reg", mem[0][j], exp_mem[0][j]);
      chk("b2b_rdata_kept", rsp_rdata[0], exp_rdata[0]);

      // Reset during RWAIT aborts the read
      @(negedge clk);
      chk("abort_ready", {31'h0, cmd_ready[1]}, 32'h1);
      cmd_valid[1] = 1'b1; cmd_write[1] = 1'b0; cmd_address[1] = 2'd0;
      @(negedge clk);
      cmd_valid[1] = 1'b0;
      @(negedge clk);
      chk("rwait_cs", {31'h0, chipselect[1]}, 32'h0);
      chk("rwait_address", {30'h0, address[1]}, 32'h0);
      r0 = rsp_cnt[1];
      reset[1] = 1'b1;
      #1;
      chk("abort_cs", {31'h0, chipselect[1]}, 32'h0);
      chk("abort_write_n", {31'h0, write_n[1]}, 32'h1);
      chk("abort_rsp_valid", {31'h0, rsp_valid[1]}, 32'h0);
      repeat (2) @(negedge clk);
      reset[1] = 1'b0;
      exp_rdata[1] = 32'h0;
      repeat (6) @(negedge clk);
      chk("abort_no_rsp", rsp_cnt[1] - r0, 0);
      chk("abort_rdata", rsp_rdata[1], 32'h0);
      do_cmd(1, 1'b0, 1'b0, 2'd0, 32'h0);

      // Randomised commands on both instances with random stuck bits
      stuck[0] = 32'($urandom_range(15, 0));
      stuck[1] = 32'($urandom_range(15, 0));
      for (int n = 0; n < 60; n++) begin
         ri = int'($urandom_range(1, 0));
         rw = 1'($urandom_range(1, 0));
         rv = 1'($urandom_range(1, 0));
         ra = 2'($urandom_range(3, 0));
         rd = $urandom;
         do_cmd(ri, rw, rv, ra, rd);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
